// File: rtl/ex_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_seq_if
// Brief    : EX-stage <-> multiply/divide sequencer handshake and operand bus.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_A;
  logic [XLEN-1:0] i_B;
  logic            i_flush;
  logic            o_stall;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  // EX stage drives requests and consumes the result
  modport master (
    output i_start, i_op, i_A, i_B, i_flush,
    input  o_stall, o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_A, i_B, i_flush,
    output o_stall, o_busy, o_done, o_result
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_seq
// Brief    : Iterative RV32M multiply/divide unit, one bit per cycle, with
//            divide-by-zero / signed-overflow fast paths and pipeline stall.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  ex_muldiv_seq_if.slave     mdu
);

  localparam int                 c_CNT_W    = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [2:0] c_OP_MULH   = 3'b001;
  localparam logic [2:0] c_OP_MULHSU = 3'b010;
  localparam logic [2:0] c_OP_DIV    = 3'b100;
  localparam logic [2:0] c_OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]        r_op;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  // ---------------------------------------------------------------- accept
  logic            w_signed_a;
  logic            w_signed_b;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_signed_a = (mdu.i_op == c_OP_MULH) | (mdu.i_op == c_OP_MULHSU) |
                      (mdu.i_op == c_OP_DIV)  | (mdu.i_op == c_OP_REM);
  assign w_signed_b = (mdu.i_op == c_OP_MULH) | (mdu.i_op == c_OP_DIV) |
                      (mdu.i_op == c_OP_REM);
  assign w_sign_a   = w_signed_a & mdu.i_A[XLEN-1];
  assign w_sign_b   = w_signed_b & mdu.i_B[XLEN-1];
  assign w_mag_a    = w_sign_a ? -mdu.i_A : mdu.i_A;
  assign w_mag_b    = w_sign_b ? -mdu.i_B : mdu.i_B;

  assign w_div_zero = mdu.i_op[2] & (mdu.i_B == '0);
  assign w_div_ovf  = ((mdu.i_op == c_OP_DIV) | (mdu.i_op == c_OP_REM)) &
                      (mdu.i_A == c_MIN_NEG) & (mdu.i_B == '1);
  assign w_fast     = w_div_zero | w_div_ovf;
  // RISC-V defined results: x/0 -> all ones, x%0 -> x; MIN/-1 -> MIN, rem 0
  assign w_fast_res = w_div_zero ? (mdu.i_op[1] ? mdu.i_A : '1)
                                 : (mdu.i_op[1] ? '0 : c_MIN_NEG);

  // ------------------------------------------------------------- iteration
  logic              w_is_div;
  logic [XLEN:0]     w_rem_ext;
  logic [XLEN+1:0]   w_add_a;
  logic [XLEN+1:0]   w_add_b;
  logic              w_add_c;
  logic [XLEN+1:0]   w_sum;
  logic [2*XLEN-1:0] w_acc_nxt;

  assign w_is_div  = r_op[2];
  // Remainder after the {rem,quot} left shift, keeping the bit shifted out
  assign w_rem_ext = r_acc[2*XLEN-1:XLEN-1];

  always_comb begin
    w_add_a = {2'b00, r_acc[2*XLEN-1:XLEN]};
    w_add_b = '0;
    w_add_c = 1'b0;
    if (w_is_div) begin
      w_add_a = {1'b0, w_rem_ext};
      w_add_b = ~{2'b00, r_opnd};
      w_add_c = 1'b1;
    end else if (r_acc[0]) begin
      w_add_b = {2'b00, r_opnd};
    end
  end

  assign w_sum = w_add_a + w_add_b + {{(XLEN+1){1'b0}}, w_add_c};

  always_comb begin
    w_acc_nxt = {w_sum[XLEN:0], r_acc[XLEN-1:1]};
    if (w_is_div) begin
      if (!w_sum[XLEN+1]) begin
        w_acc_nxt = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_rem_ext[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
    end
  end

  // --------------------------------------------------------------- fix-up
  logic [2*XLEN-1:0] w_prod_neg;
  logic [2*XLEN-1:0] w_prod_sel;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_quot_neg;
  logic [XLEN-1:0]   w_rem_neg;
  logic [XLEN-1:0]   w_fix;

  assign w_prod_neg = -w_acc_nxt;
  assign w_prod_sel = (r_sign_a ^ r_sign_b) ? w_prod_neg : w_acc_nxt;
  assign w_quot     = w_acc_nxt[XLEN-1:0];
  assign w_rem      = w_acc_nxt[2*XLEN-1:XLEN];
  assign w_quot_neg = -w_quot;
  assign w_rem_neg  = -w_rem;

  always_comb begin
    w_fix = w_prod_sel[2*XLEN-1:XLEN];
    if (r_op[2]) begin
      if (r_op[1]) begin
        w_fix = r_sign_a ? w_rem_neg : w_rem;
      end else begin
        w_fix = (r_sign_a ^ r_sign_b) ? w_quot_neg : w_quot;
      end
    end else if (r_op[1:0] == 2'b00) begin
      w_fix = w_prod_sel[XLEN-1:0];
    end
  end

  // ------------------------------------------------------------ sequencer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (mdu.i_flush) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (mdu.i_start) begin
            r_op     <= mdu.i_op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_cnt    <= '0;
            // Multiply: multiplier in the low half, multiplicand in r_opnd.
            // Divide: dividend in the quotient half, divisor in r_opnd.
            r_opnd   <= mdu.i_op[2] ? w_mag_b : w_mag_a;
            r_acc    <= {{XLEN{1'b0}}, (mdu.i_op[2] ? w_mag_a : w_mag_b)};
            if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= c_DONE;
            end else begin
              r_state  <= c_CALC;
            end
          end
        end
        c_CALC: begin
          r_acc <= w_acc_nxt;
          if (r_cnt == c_CNT_LAST) begin
            r_cnt    <= '0;
            r_result <= w_fix;
            r_state  <= c_DONE;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  logic w_done;

  assign w_done       = (r_state == c_DONE);
  assign mdu.o_done   = w_done;
  assign mdu.o_busy   = (r_state != c_IDLE);
  assign mdu.o_stall  = mdu.i_start & ~w_done;
  assign mdu.o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_seq
// Brief    : Directed self-checking bench for the RV32M multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_seq;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  ex_muldiv_seq_if #(.XLEN(32)) mdu ();

  ex_muldiv_seq #(.XLEN(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .mdu   (mdu)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // lat = edges between the accept edge and the edge after which o_done is seen
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit keep_start);
    int n;
    int stall_hi;
    n = 0;
    stall_hi = 0;
    mdu.i_start = 1'b1;
    mdu.i_op    = op;
    mdu.i_A     = a;
    mdu.i_B     = b;
    #1;
    check({tag, "_stall_accept"}, 32'(mdu.o_stall), 32'd1);
    tick();
    mdu.i_A = $urandom;
    mdu.i_B = $urandom;
    while (mdu.o_done !== 1'b1 && n < 40) begin
      if (mdu.o_stall === 1'b1) stall_hi++;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_stall_cycles"}, 32'(stall_hi), 32'(lat));
    check({tag, "_result"}, mdu.o_result, exp);
    check({tag, "_stall_done"}, 32'(mdu.o_stall), 32'd0);
    if (!keep_start) mdu.i_start = 1'b0;
    tick();
    check({tag, "_busy_after"}, 32'(mdu.o_busy), 32'd0);
    check({tag, "_done_after"}, 32'(mdu.o_done), 32'd0);
  endtask

  initial begin
    int saw_done;
    rst         = 1'b1;
    mdu.i_start = 1'b0;
    mdu.i_op    = 3'b000;
    mdu.i_A     = '0;
    mdu.i_B     = '0;
    mdu.i_flush = 1'b0;
    tick();
    tick();
    check("rst_busy",   32'(mdu.o_busy),  32'd0);
    check("rst_done",   32'(mdu.o_done),  32'd0);
    check("rst_stall",  32'(mdu.o_stall), 32'd0);
    check("rst_result", mdu.o_result,     32'd0);
    rst = 1'b0;
    tick();

    // Multiply variants
    run_op("mul_7_m3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 1'b0);
    run_op("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, 1'b0);
    run_op("mulhu_min_min", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, 1'b0);
    run_op("mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 1'b0);
    run_op("mul_2p16_sq",   3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32, 1'b0);

    // Divide variants
    run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 1'b0);
    run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 1'b0);
    run_op("divu_100_7",    3'b101, 32'd100,       32'd7, 32'd14,        32, 1'b0);
    run_op("remu_100_7",    3'b111, 32'd100,       32'd7, 32'd2,         32, 1'b0);

    // Fast paths
    run_op("divu_by0",      3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 0, 1'b0);
    run_op("rem_by0",       3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 0, 1'b0);
    run_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
    run_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0);

    // Flush during the tenth iteration
    mdu.i_start = 1'b1;
    mdu.i_op    = 3'b000;
    mdu.i_A     = 32'd123;
    mdu.i_B     = 32'd456;
    tick();
    repeat (9) tick();
    mdu.i_flush = 1'b1;
    mdu.i_start = 1'b0;
    tick();
    mdu.i_flush = 1'b0;
    check("flush_busy", 32'(mdu.o_busy), 32'd0);
    check("flush_done", 32'(mdu.o_done), 32'd0);
    saw_done = 0;
    repeat (40) begin
      tick();
      if (mdu.o_done === 1'b1) saw_done++;
    end
    check("flush_no_done", 32'(saw_done), 32'd0);
    run_op("divu_9_3",      3'b101, 32'd9, 32'd3, 32'd3, 32, 1'b0);

    // Back-to-back with i_start held through the done cycle
    run_op("b2b_mul_3_5",   3'b000, 32'd3,  32'd5, 32'd15, 32, 1'b1);
    run_op("b2b_div_20_4",  3'b100, 32'd20, 32'd4, 32'd5,  32, 1'b0);

    // Reset in the middle of a calculation
    mdu.i_start = 1'b1;
    mdu.i_op    = 3'b101;
    mdu.i_A     = 32'd1000;
    mdu.i_B     = 32'd3;
    tick();
    repeat (5) tick();
    check("midrst_busy_before", 32'(mdu.o_busy), 32'd1);
    rst         = 1'b1;
    mdu.i_start = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_busy",   32'(mdu.o_busy),  32'd0);
    check("midrst_done",   32'(mdu.o_done),  32'd0);
    check("midrst_stall",  32'(mdu.o_stall), 32'd0);
    check("midrst_result", mdu.o_result,     32'd0);
    run_op("div_1000_m3",   3'b100, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 32, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU and serves MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- It latches operands from the EX stage and runs a one-bit-per-cycle shift-add or restoring-divide loop on an internal adder.
- It holds the pipeline through a combinational stall until the result is ready.
- The result is muxed into the EX result path by the EX stage on the done cycle.

Parameters:
XLEN, 32, operand/result width. Iteration counter is clog2(XLEN) bits wide.

Ports:
i_clk  input  1  clock; all state changes on rising edge.
i_rst  input  1  reset, synchronous, active-high.
i_start  input  1  M-extension instruction present in EX; held high with stable operands until the o_done cycle.
i_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
i_A  input  XLEN  rs1 value (multiplicand/dividend).
i_B  input  XLEN  rs2 value (multiplier/divisor).
i_flush  input  1  kill the in-flight operation (branch/jump redirect).
o_stall  output  1  freeze PC/IF/ID/EX registers.
o_busy  output  1  state != IDLE.
o_done  output  1  single-cycle pulse; o_result valid.
o_result  output  XLEN  rd write value.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset/flush values: i_rst forces IDLE, counter 0, o_done 0, o_result 0, and all internal operand/accumulator registers 0. i_flush does the same synchronously from any state, except that o_result is not required to clear. i_rst and i_flush both override i_start on the same edge.
- IDLE, i_start=1 at edge E0:
  - Latch op.
  - Compute operand magnitudes and sign flags. Signed operands are i_A for MULH/MULHSU/DIV/REM and i_B for MULH/DIV/REM; all others are treated as unsigned.
  - Clear the accumulator and counter.
  - Go to CALC, unless a fast path applies.
- Fast paths, from IDLE at E0, go directly to DONE with the result loaded:
  - Divide by zero (i_B==0, op[2]=1): quotient all ones (DIV and DIVU alike); remainder = i_A unmodified.
  - Signed overflow (DIV/REM, i_A=0x8000_0000, i_B=0xFFFF_FFFF): quotient 0x8000_0000; remainder 0.
  - Result is visible at o_done one cycle after E0.
- CALC: one iteration per edge for XLEN edges (E1..EXLEN); at EXLEN go to DONE.
  - Multiply: 2*XLEN product register. If the multiplier LSB is set, add the multiplicand into the upper half, then shift right by 1 with the carry-out entering the MSB.
  - Divide (restoring):
    - Shift the {rem, quot} pair left by 1.
    - Compute trial = rem - divisor.
    - If trial is non-negative (no borrow), rem = trial and the quotient LSB = 1.
    - Use an XLEN+1-bit subtract so the borrow is exact.
- Entering DONE: apply the sign fix-up and register o_result.
  - MUL: low half of the product.
  - MULH*: high half of the product.
  - Negate the product if the sign flags differ (signed-participating ops only).
  - Quotient: negated if the signs differ (DIV).
  - Remainder: takes the dividend's sign (REM).
  - Standard latency: o_done high in the cycle after EXLEN, i.e. XLEN cycles after the accept edge (32 for XLEN=32).
- DONE: o_done=1 for exactly one cycle; go to IDLE on the next edge unconditionally. i_start seen in DONE is not re-accepted.
- o_stall = i_start & ~o_done, combinational.
  - High on the accept cycle and throughout CALC.
  - Low on the done cycle, so EX advances and captures o_result.
  - An instruction arriving the next cycle is accepted from IDLE (back-to-back supported, one idle-free turnaround).
- o_result holds its last value outside DONE. Consumers use it only when o_done=1.
- i_A/i_B changes after E0 have no effect (operands latched).

Test Plan:
- MUL i_A=7, i_B=0xFFFF_FFFD (-3) -> o_done exactly 32 cycles after accept, o_result=0xFFFF_FFEB; o_stall high for 32 cycles then low on the done cycle.
- MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000. MULHU same operands -> 0x4000_0000. MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF. MUL 0x0001_0000 x 0x0001_0000 -> 0.
- DIV -7/2 -> 0xFFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each done 32 cycles after accept.
- Fast paths:
  - DIVU 0x1234/0 -> 0xFFFF_FFFF; REM 0x1234/0 -> 0x1234; DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM same operands -> 0.
  - All four: o_done the cycle after accept, and o_stall high for exactly one cycle.
- Flush and reset mid-operation:
  - i_flush at iteration 10 -> IDLE next edge, no o_done, o_busy=0. A subsequent DIVU 9/3 returns 3 correctly.
  - i_rst asserted mid-CALC -> all outputs reset values next edge.
- Back-to-back MUL 3x5 then DIV 20/4 with i_start continuous across the done cycle -> results 15 then 5. Second accept occurs the cycle after the first o_done, and no op is accepted in the DONE state.
